// File: rtl/affine_seq_pkg.sv
// affine_seq_pkg
//   Shared definitions for the affine_seq sequencer and its ALU:
//   - state_t : sequencer states, one ALU operation per compute state.
//   - RA/RB/RADD/RMUL : ALU function codes (pass a, pass b, add, Q1.7 multiply).
package affine_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M11,
        M12,
        ADD1,
        OFS1,
        M21,
        M22,
        ADD2,
        OFS2,
        DONE
    } state_t;

    localparam logic [1:0] RA   = 2'd0;
    localparam logic [1:0] RB   = 2'd1;
    localparam logic [1:0] RADD = 2'd2;
    localparam logic [1:0] RMUL = 2'd3;

endpackage

// File: rtl/affine_seq_alu.sv
// alu
//   Combinational picoMIPS-style ALU.
//   Ports:
//     func   in  2  operation (RA, RB, RADD, RMUL from affine_seq_pkg)
//     a, b   in  n  signed operands
//     result out n  RA: a, RB: b, RADD: a+b mod 2^n,
//                   RMUL: bits [2n-2:n-1] of the full signed product (Q1.7 scaling)
module alu
    import affine_seq_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [1:0]   func,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] result
);

    logic signed [2*n-1:0] a_ext;
    logic signed [2*n-1:0] b_ext;

    assign a_ext = {{n{a[n-1]}}, a};
    assign b_ext = {{n{b[n-1]}}, b};

    always_comb begin
        result = a;
        case (func)
            RA:      result = a;
            RB:      result = b;
            RADD:    result = a + b;
            // Arithmetic shift then keep the low n bits == product[2n-2:n-1],
            // which truncates toward -inf.
            RMUL:    result = n'((a_ext * b_ext) >>> (n - 1));
            default: result = a;
        endcase
    end

endmodule

// File: rtl/affine_seq.sv
// affine_seq
//   Multi-cycle sequencer computing xo = a11*x + a12*y + b1 and
//   yo = a21*x + a22*y + b2 through a single shared ALU, one operation per cycle.
//   Optional feature macro: AFFINE_SEQ_SAT_EN (saturating adds + sticky ovf).
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start               run request, sampled only in IDLE
//     x, y                signed input point
//     a11,a12,a21,a22     signed Q1.7 coefficients
//     b1, b2              signed integer offsets
//     busy                high from the cycle after an accepted start through DONE
//     done                one-cycle pulse; xo/yo valid from this cycle
//     xo, yo              results, held until next completion or reset
//     ovf                 sticky add-overflow flag for the current/last run
//   Handshake: start is a level request; it is accepted on a rising edge where the
//   sequencer is IDLE and ignored (not queued) otherwise. Holding start high gives
//   back-to-back runs, one every 10 cycles.
module affine_seq
    import affine_seq_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic [n-1:0] a11,
    input  logic [n-1:0] a12,
    input  logic [n-1:0] a21,
    input  logic [n-1:0] a22,
    input  logic [n-1:0] b1,
    input  logic [n-1:0] b2,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] xo,
    output logic [n-1:0] yo,
    output logic         ovf
);

    state_t       state_q, state_d;
    logic [n-1:0] x_q, x_d, y_q, y_d;
    logic [n-1:0] a11_q, a11_d, a12_q, a12_d, a21_q, a21_d, a22_q, a22_d;
    logic [n-1:0] b1_q, b1_d, b2_q, b2_d;
    logic [n-1:0] p0_q, p0_d, p1_q, p1_d, xr_q, xr_d;
    logic [n-1:0] xo_q, xo_d, yo_q, yo_d;

    logic [1:0]   alu_func;
    logic [n-1:0] alu_a, alu_b, alu_res, add_res;

    alu #(.n(n)) u_alu (
        .func   (alu_func),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res)
    );

    // ALU operand/function select; depends on state only.
    always_comb begin
        alu_func = RA;
        alu_a    = '0;
        alu_b    = '0;
        case (state_q)
            M11:  begin alu_func = RMUL; alu_a = a11_q; alu_b = x_q;  end
            M12:  begin alu_func = RMUL; alu_a = a12_q; alu_b = y_q;  end
            ADD1: begin alu_func = RADD; alu_a = p0_q;  alu_b = p1_q; end
            OFS1: begin alu_func = RADD; alu_a = p0_q;  alu_b = b1_q; end
            M21:  begin alu_func = RMUL; alu_a = a21_q; alu_b = x_q;  end
            M22:  begin alu_func = RMUL; alu_a = a22_q; alu_b = y_q;  end
            ADD2: begin alu_func = RADD; alu_a = p0_q;  alu_b = p1_q; end
            OFS2: begin alu_func = RADD; alu_a = p0_q;  alu_b = b2_q; end
            default: ;
        endcase
    end

`ifdef AFFINE_SEQ_SAT_EN
    logic add_ovf;
    logic ovf_q, ovf_d;

    // Signed overflow: operands agree in sign, result does not. Clamp by operand sign.
    always_comb begin
        add_ovf = (alu_func == RADD) && (alu_a[n-1] == alu_b[n-1])
                  && (alu_res[n-1] != alu_a[n-1]);
        add_res = alu_res;
        if (add_ovf) begin
            add_res = alu_a[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        end
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            ovf_d = 1'b0;
        end else if (add_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    always_comb add_res = alu_res;
    assign ovf = 1'b0;
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        x_d = x_q;   y_d = y_q;
        a11_d = a11_q; a12_d = a12_q; a21_d = a21_q; a22_d = a22_q;
        b1_d = b1_q; b2_d = b2_q;
        p0_d = p0_q; p1_d = p1_q; xr_d = xr_q;
        xo_d = xo_q; yo_d = yo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d = x;     y_d = y;
                    a11_d = a11; a12_d = a12; a21_d = a21; a22_d = a22;
                    b1_d = b1;   b2_d = b2;
                    state_d = M11;
                end
            end
            M11:  begin p0_d = alu_res; state_d = M12;  end
            M12:  begin p1_d = alu_res; state_d = ADD1; end
            ADD1: begin p0_d = add_res; state_d = OFS1; end
            OFS1: begin xr_d = add_res; state_d = M21;  end
            M21:  begin p0_d = alu_res; state_d = M22;  end
            M22:  begin p1_d = alu_res; state_d = ADD2; end
            ADD2: begin p0_d = add_res; state_d = OFS2; end
            // xo is staged in xr until here so both outputs change on the same edge.
            OFS2: begin xo_d = xr_q; yo_d = add_res; state_d = DONE; end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q <= '0;   y_q <= '0;
            a11_q <= '0; a12_q <= '0; a21_q <= '0; a22_q <= '0;
            b1_q <= '0;  b2_q <= '0;
            p0_q <= '0;  p1_q <= '0;  xr_q <= '0;
            xo_q <= '0;  yo_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;     y_q <= y_d;
            a11_q <= a11_d; a12_q <= a12_d; a21_q <= a21_d; a22_q <= a22_d;
            b1_q <= b1_d;   b2_q <= b2_d;
            p0_q <= p0_d;   p1_q <= p1_d;   xr_q <= xr_d;
            xo_q <= xo_d;   yo_q <= yo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign xo   = xo_q;
    assign yo   = yo_q;

endmodule

// File: tb/tb_affine_seq.sv
module tb_affine_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] x, y, a11, a12, a21, a22, b1, b2;
    logic         busy, done, ovf;
    logic [N-1:0] xo, yo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*N-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    affine_seq #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .a11   (a11),
        .a12   (a12),
        .a21   (a21),
        .a22   (a22),
        .b1    (b1),
        .b2    (b2),
        .busy  (busy),
        .done  (done),
        .xo    (xo),
        .yo    (yo),
        .ovf   (ovf)
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_vec(input int xv, input int yv, input int c11, input int c12,
                           input int c21, input int c22, input int o1, input int o2);
        x   = xv[N-1:0];  y   = yv[N-1:0];
        a11 = c11[N-1:0]; a12 = c12[N-1:0];
        a21 = c21[N-1:0]; a22 = c22[N-1:0];
        b1  = o1[N-1:0];  b2  = o2[N-1:0];
    endtask

    task automatic scramble_inputs();
        x   = N'($urandom_range(0, 255)); y   = N'($urandom_range(0, 255));
        a11 = N'($urandom_range(0, 255)); a12 = N'($urandom_range(0, 255));
        a21 = N'($urandom_range(0, 255)); a22 = N'($urandom_range(0, 255));
        b1  = N'($urandom_range(0, 255)); b2  = N'($urandom_range(0, 255));
    endtask

    // One start pulse; edges counted inclusive of the accepting edge.
    task automatic run_one(input string tag, input int exp_x, input int exp_y,
                           input int exp_o, input bit scramble);
        int edges;
        int busy_cnt;
        bit got;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (scramble) scramble_inputs();
        edges = 1; busy_cnt = 0; got = 1'b0;
        while (!got && edges < 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                edges++;
                if (scramble) scramble_inputs();
            end
        end
        check_val({tag, "_done_seen"}, 32'(got), 1);
        check_val({tag, "_latency"}, edges, 9);
        check_val({tag, "_busy_cycles"}, busy_cnt, 9);
        check_val({tag, "_xo"}, 32'($signed(xo)), exp_x);
        check_val({tag, "_yo"}, 32'($signed(yo)), exp_y);
        check_val({tag, "_ovf"}, 32'(ovf), exp_o);
        @(negedge clk);
        check_val({tag, "_done_width"}, 32'(done), 0);
        check_val({tag, "_idle_busy"}, 32'(busy), 0);
        check_val({tag, "_xo_held"}, 32'($signed(xo)), exp_x);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        int last;
        int idle_wait;
        logic prev_done;

        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_xo", 32'($signed(xo)), 0);
        check_val("rst_yo", 32'($signed(yo)), 0);
        check_val("rst_ovf", 32'(ovf), 0);
        reset = 1'b0;

        // Test 1: basic transform
        set_vec(100, 20, 64, 64, -64, 64, 10, 0);
        run_one("t1", 70, -40, 0, 1'b0);

        // Test 2: 126 + 126 overflows the add
        set_vec(127, 127, 127, 127, 0, 0, 0, 0);
`ifdef AFFINE_SEQ_SAT_EN
        run_one("t2", 127, 0, 1, 1'b0);
`else
        run_one("t2", -4, 0, 0, 1'b0);
`endif

        // Test 3: -1 + -128 overflows the offset add
        set_vec(-2, 0, 64, 0, 0, 0, -128, 0);
`ifdef AFFINE_SEQ_SAT_EN
        run_one("t3", -128, 0, 1, 1'b0);
`else
        run_one("t3", 127, 0, 0, 1'b0);
`endif

        // Test 4: start held high 35 cycles -> done at 9, 19, 29
        set_vec(100, 20, 64, 64, -64, 64, 10, 0);
        repeat (3) exp_q.push_back({8'd70, 8'hD8});
        @(negedge clk); start = 1'b1;
        pulses = 0; last = 0; prev_done = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (done) begin
                check_val("t4_width", 32'(prev_done), 0);
                if (pulses == 0) check_val("t4_first", k, 9);
                else             check_val("t4_period", k - last, 10);
                if (exp_q.size() > 0) check_val("t4_res", 32'({xo, yo}), 32'(exp_q.pop_front()));
                else                  check_val("t4_extra_pulse", pulses + 1, 3);
                pulses++;
                last = k;
            end
            prev_done = done;
        end
        start = 1'b0;
        check_val("t4_pulses", pulses, 3);
        check_val("t4_queue_empty", exp_q.size(), 0);
        idle_wait = 0;
        while (busy && idle_wait < 20) begin
            @(negedge clk);
            idle_wait++;
        end
        check_val("t4_drain_idle", 32'(busy), 0);

        // Test 5: reset sampled during ADD1
        set_vec(100, 20, 64, 64, -64, 64, 10, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;   // M11
        @(negedge clk);                 // M12
        @(negedge clk); reset = 1'b1;   // ADD1
        @(negedge clk); reset = 1'b0;
        check_val("t5_busy", 32'(busy), 0);
        check_val("t5_done", 32'(done), 0);
        check_val("t5_xo", 32'($signed(xo)), 0);
        check_val("t5_yo", 32'($signed(yo)), 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("t5_no_done", pulses, 0);
        run_one("t5_rerun", 70, -40, 0, 1'b0);

        // Test 6: inputs scrambled every cycle after the accepting edge
        set_vec(100, 20, 64, 64, -64, 64, 10, 0);
        run_one("t6", 70, -40, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
